alu_lock_arbiter: RTL and testbench
===================================

ALU_LOCK_ARBITER -- requirements
Module: alu_lock_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of SIC requesters sharing one ALU.
REQ-002 SHALL have parameter ID_WIDTH, default 6, width of issue_id (wrapping age tag).
REQ-003 SHALL have parameter OP_W, default 4, width of ALU op field.
REQ-004 clk  input  1  clock; all state updates on posedge clk.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req  input  NUM_REQ  per-SIC lock request (level).
REQ-007 req_issue_id  input  NUM_REQ x ID_WIDTH  issue_id of each requester's instruction.
REQ-008 release_lock  input  NUM_REQ  per-SIC one-cycle release pulse.
REQ-009 in_op / in_a / in_b  input  NUM_REQ x OP_W / 32 / 32  per-SIC ALU request fields.
REQ-010 grant  output  NUM_REQ  one-hot (or zero) lock grant, registered.
REQ-011 alu_op / alu_a / alu_b  output  OP_W / 32 / 32  request fields of current owner to shared ALU.
REQ-012 locked  output  1  lock currently held.
REQ-013 err_stray_release  output  1  sticky: release seen from a non-owner.

Function
REQ-014 State SHALL be: locked bit, owner index (clog2(NUM_REQ) bits), sticky error bit.
REQ-015 grant[i] SHALL equal locked && owner==i, purely from registers (no input-to-grant combinational path).
REQ-016 Arbitration SHALL occur in a cycle when free = !locked || release_lock[owner].
REQ-017 Candidate set SHALL be req[i] with i != owner-being-released.
REQ-018 Winner SHALL be oldest candidate: a older than b iff (a - b) mod 2^ID_WIDTH has MSB set; equal ids -> lower index wins.
REQ-019 If free and a winner exists, next cycle: locked=1, owner=winner; if free and none, next cycle locked=0.
REQ-020 Latency: req rising with lock free at cycle t SHALL yield grant at t+1.
REQ-021 Hand-off: owner release at cycle t with another request pending SHALL yield new grant at t+1 (no idle cycle).
REQ-022 Lock SHALL be held regardless of owner's req dropping; only release_lock[owner] frees it.
REQ-023 release_lock[i] with i != owner, or any release while !locked, SHALL be ignored for state and set err_stray_release (covers SIC aborting before grant).
REQ-024 Multiple release bits in one cycle: only owner's bit acts; others set error.
REQ-025 alu_op/a/b SHALL mux in_* of owner combinationally when locked; SHALL be 0 when !locked.
REQ-026 Requests arriving while locked SHALL wait; no pre-emption by older ids.
REQ-027 Non-owner request SHALL not be granted more than once per lock period; grant stays one-hot.

Reset
REQ-028 On rst_n low (any time, mid-lock included): locked=0, owner=0, err_stray_release=0, grant=0 immediately.
REQ-029 First arbitration SHALL occur on first posedge after rst_n deasserts.

Structure
REQ-030 Shared package SHALL hold the rpl request struct (req, req_issue_id, release_lock) and alu request struct (op, a, b) used here and in SIC units.
REQ-031 Age comparison + oldest-pick SHALL be one sub-module, issue_age_pick (NUM_REQ, ID_WIDTH), combinational tree returning valid+index.
REQ-032 Target size 120-250 lines RTL total.

Verification
REQ-033 Single: req[2]=1 id=5 at t0, free -> grant=0b0100 at t0+1, alu_a=in_a[2]; release[2] at t0+3 -> grant=0 at t0+4.
REQ-034 Age: req[0] id=10, req[3] id=7 same cycle -> grant[3] first; after release[3], grant[0] next cycle.
REQ-035 Wrap: ID_WIDTH=6, req[1] id=62, req[2] id=1 -> grant[1] (62 older than 1).
REQ-036 Stray: owner=1, release[0] pulses -> grant unchanged, err_stray_release=1 sticky until reset.
REQ-037 Hand-off: owner 0 releases at t while req[1] pending -> grant=0b0010 at t+1, never 0 between.
REQ-038 Reset mid-lock: grant=0b1000, rst_n low -> grant=0, locked=0 without clock edge; req[3] held -> grant at first edge after release.

Source files
------------

// File: rtl/alu_lock_arbiter_pkg.sv
// Shared types for the ALU lock arbiter and the SIC units that request the ALU.
// Latency: n/a (types and widths only).
// Backpressure: n/a. Contents: per-requester lock record and ALU operand record.
package alu_lock_arbiter_pkg;

    localparam int ALU_DATA_W = 32;
    localparam int ALU_OP_W   = 4;
    localparam int ISSUE_ID_W = 6;

    // What one SIC presents to the lock: request level, its age tag, release pulse.
    typedef struct packed {
        logic                  req;
        logic [ISSUE_ID_W-1:0] issue_id;
        logic                  release_lock;
    } rpl_req_t;

    // Operands one SIC wants executed on the shared ALU.
    typedef struct packed {
        logic [ALU_OP_W-1:0]   op;
        logic [ALU_DATA_W-1:0] a;
        logic [ALU_DATA_W-1:0] b;
    } alu_req_t;

endpackage

// File: rtl/alu_lock_arbiter_if.sv
// Bundle between the SIC requesters and the ALU lock arbiter.
// Latency: n/a (wires only).
// Backpressure: none; requesters hold req until granted. master = SIC side, slave = arbiter.
interface alu_lock_arbiter_if #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 6,
    parameter int OP_W     = 4
);
    logic [NUM_REQ-1:0]                req;
    logic [NUM_REQ-1:0][ID_WIDTH-1:0]  req_issue_id;
    logic [NUM_REQ-1:0]                release_lock;
    logic [NUM_REQ-1:0][OP_W-1:0]      in_op;
    logic [NUM_REQ-1:0][31:0]          in_a;
    logic [NUM_REQ-1:0][31:0]          in_b;

    logic [NUM_REQ-1:0]                grant;
    logic [OP_W-1:0]                   alu_op;
    logic [31:0]                       alu_a;
    logic [31:0]                       alu_b;
    logic                              locked;
    logic                              err_stray_release;

    modport master (
        output req, req_issue_id, release_lock, in_op, in_a, in_b,
        input  grant, alu_op, alu_a, alu_b, locked, err_stray_release
    );

    modport slave (
        input  req, req_issue_id, release_lock, in_op, in_a, in_b,
        output grant, alu_op, alu_a, alu_b, locked, err_stray_release
    );
endinterface

// File: rtl/alu_lock_arbiter_issue_age_pick.sv
// Picks the oldest valid requester by wrapping issue_id; ties go to the lower index.
// Latency: combinational. Backpressure: none.
// Ports: vld/ids per requester in; pick_vld + pick_idx out.
module issue_age_pick #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 6,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0]               vld,
    input  logic [NUM_REQ-1:0][ID_WIDTH-1:0] ids,
    output logic                             pick_vld,
    output logic [IDX_W-1:0]                 pick_idx
);
    // Binary tree padded to a power of two; node n has children 2n+1 (lower
    // indices) and 2n+2, leaves start at P-1.
    localparam int P = 1 << IDX_W;

    for (genvar n = 0; n < 2*P-1; n++) begin : g_node
        logic                v;
        logic [ID_WIDTH-1:0] id;
        logic [IDX_W-1:0]    idx;

        if (n >= P-1) begin : g_leaf
            localparam int J = n - (P-1);
            if (J < NUM_REQ) begin : g_real
                assign v   = vld[J];
                assign id  = ids[J];
                assign idx = IDX_W'(J);
            end else begin : g_pad
                assign v   = 1'b0;
                assign id  = '0;
                assign idx = '0;
            end
        end else begin : g_join
            logic [ID_WIDTH-1:0] diff;
            logic                take_r;
            // Right is older when (right - left) mod 2^ID_WIDTH has its MSB set;
            // equal ids leave the left (lower index) side in place.
            assign diff   = g_node[2*n+2].id - g_node[2*n+1].id;
            assign take_r = g_node[2*n+2].v && (!g_node[2*n+1].v || diff[ID_WIDTH-1]);
            assign v      = g_node[2*n+1].v | g_node[2*n+2].v;
            assign id     = take_r ? g_node[2*n+2].id  : g_node[2*n+1].id;
            assign idx    = take_r ? g_node[2*n+2].idx : g_node[2*n+1].idx;
        end
    end

    assign pick_vld = g_node[0].v;
    assign pick_idx = g_node[0].idx;

endmodule

// File: rtl/alu_lock_arbiter.sv
// Lock arbiter granting one SIC at a time exclusive use of the shared ALU, oldest issue_id first.
// Latency: request with lock free -> grant next cycle; owner release hands off next cycle.
// Backpressure: losers keep req high and wait; holder keeps the lock until it pulses release.
// Ports: clk, rst_n (async active-low), bus (slave side of alu_lock_arbiter_if).
module alu_lock_arbiter
    import alu_lock_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = ISSUE_ID_W,
    parameter int OP_W     = ALU_OP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_lock_arbiter_if.slave bus
);
    localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic             locked_q, locked_d;
    logic [OWN_W-1:0] owner_q,  owner_d;
    logic             err_q,    err_d;

    rpl_req_t                         rpl [NUM_REQ];
    logic [NUM_REQ-1:0]               req_vec, rel_vec, owner_oh, cand, stray;
    logic [NUM_REQ-1:0][ID_WIDTH-1:0] id_vec;
    logic                             owner_rel, free;
    logic                             pick_vld;
    logic [OWN_W-1:0]                 pick_idx;
    alu_req_t                         alu_sel;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            rpl[i].req          = bus.req[i];
            rpl[i].issue_id     = bus.req_issue_id[i];
            rpl[i].release_lock = bus.release_lock[i];
        end
    end

    always_comb begin
        req_vec = '0;
        rel_vec = '0;
        id_vec  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_vec[i] = rpl[i].req;
            rel_vec[i] = rpl[i].release_lock;
            id_vec[i]  = rpl[i].issue_id;
        end
    end

    // Owner decode from flops only, so grant has no path from any input.
    always_comb begin
        owner_oh = '0;
        if (locked_q) begin
            owner_oh[owner_q] = 1'b1;
        end
    end

    // The releasing owner is dropped from the candidates so it cannot re-win the
    // lock it is giving up; everyone else may take it over the same cycle.
    assign owner_rel = |(owner_oh & rel_vec);
    assign free      = !locked_q || owner_rel;
    assign cand      = req_vec & ~(owner_rel ? owner_oh : '0);
    assign stray     = rel_vec & ~owner_oh;

    issue_age_pick #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_pick (
        .vld      (cand),
        .ids      (id_vec),
        .pick_vld (pick_vld),
        .pick_idx (pick_idx)
    );

    always_comb begin
        locked_d = locked_q;
        owner_d  = owner_q;
        err_d    = err_q | (|stray);
        if (free) begin
            locked_d = pick_vld;
            if (pick_vld) begin
                owner_d = pick_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked_q <= 1'b0;
            owner_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            locked_q <= locked_d;
            owner_q  <= owner_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        alu_sel = '0;
        if (locked_q) begin
            alu_sel.op = bus.in_op[owner_q];
            alu_sel.a  = bus.in_a[owner_q];
            alu_sel.b  = bus.in_b[owner_q];
        end
    end

    assign bus.grant             = owner_oh;
    assign bus.locked            = locked_q;
    assign bus.err_stray_release = err_q;
    assign bus.alu_op            = alu_sel.op;
    assign bus.alu_a             = alu_sel.a;
    assign bus.alu_b             = alu_sel.b;

endmodule

// File: tb/tb_alu_lock_arbiter.sv
// Directed bench for alu_lock_arbiter: vector table plus reset-mid-lock sequence.
// Latency: inputs driven 1 ns after posedge, outputs sampled 1 ns after the next posedge.
// Backpressure: n/a.
module tb_alu_lock_arbiter;

    localparam int N  = 4;
    localparam int IW = 6;
    localparam int OW = 4;

    logic clk;
    logic rst_n;

    alu_lock_arbiter_if #(.NUM_REQ(N), .ID_WIDTH(IW), .OP_W(OW)) bus ();

    alu_lock_arbiter #(.NUM_REQ(N), .ID_WIDTH(IW), .OP_W(OW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [N-1:0]         req;
        logic [N-1:0][IW-1:0] ids;
        logic [N-1:0]         rel;
        logic [N-1:0]         grant;
        logic                 err;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    function automatic logic [31:0] a_val(int i);
        return 32'hA5A5_0000 + 32'(i) * 32'h111;
    endfunction

    function automatic logic [31:0] b_val(int i);
        return 32'h5A5A_0000 + 32'(i) * 32'h22;
    endfunction

    function automatic logic [OW-1:0] op_val(int i);
        return OW'(i + 1);
    endfunction

    function automatic logic [31:0] exp_a(logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return a_val(i);
        return 32'h0;
    endfunction

    function automatic logic [31:0] exp_b(logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return b_val(i);
        return 32'h0;
    endfunction

    function automatic logic [OW-1:0] exp_op(logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return op_val(i);
        return '0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [N-1:0] g, input logic e);
        chk({tag, " grant"},  32'(bus.grant),             32'(g));
        chk({tag, " locked"}, 32'(bus.locked),            32'(|g));
        chk({tag, " err"},    32'(bus.err_stray_release), 32'(e));
        chk({tag, " alu_a"},  bus.alu_a,                  exp_a(g));
        chk({tag, " alu_b"},  bus.alu_b,                  exp_b(g));
        chk({tag, " alu_op"}, 32'(bus.alu_op),            32'(exp_op(g)));
    endtask

    initial begin
        // {id3, id2, id1, id0}
        vecs[0]  = '{req:4'b0100, ids:{6'd0, 6'd5, 6'd0, 6'd0},  rel:4'b0000, grant:4'b0100, err:1'b0};
        vecs[1]  = '{req:4'b0100, ids:{6'd0, 6'd5, 6'd0, 6'd0},  rel:4'b0000, grant:4'b0100, err:1'b0};
        vecs[2]  = '{req:4'b0000, ids:'0,                        rel:4'b0000, grant:4'b0100, err:1'b0};
        vecs[3]  = '{req:4'b0000, ids:'0,                        rel:4'b0100, grant:4'b0000, err:1'b0};
        vecs[4]  = '{req:4'b1001, ids:{6'd7, 6'd0, 6'd0, 6'd10}, rel:4'b0000, grant:4'b1000, err:1'b0};
        vecs[5]  = '{req:4'b1001, ids:{6'd7, 6'd0, 6'd0, 6'd10}, rel:4'b1000, grant:4'b0001, err:1'b0};
        vecs[6]  = '{req:4'b1001, ids:{6'd7, 6'd0, 6'd0, 6'd10}, rel:4'b0001, grant:4'b1000, err:1'b0};
        vecs[7]  = '{req:4'b0000, ids:'0,                        rel:4'b1000, grant:4'b0000, err:1'b0};
        vecs[8]  = '{req:4'b0110, ids:{6'd0, 6'd1, 6'd62, 6'd0}, rel:4'b0000, grant:4'b0010, err:1'b0};
        vecs[9]  = '{req:4'b0110, ids:{6'd0, 6'd1, 6'd62, 6'd0}, rel:4'b0001, grant:4'b0010, err:1'b1};
        vecs[10] = '{req:4'b0000, ids:'0,                        rel:4'b0000, grant:4'b0010, err:1'b1};
        vecs[11] = '{req:4'b0000, ids:'0,                        rel:4'b0010, grant:4'b0000, err:1'b1};
        vecs[12] = '{req:4'b0000, ids:'0,                        rel:4'b0100, grant:4'b0000, err:1'b1};
        vecs[13] = '{req:4'b0101, ids:{6'd0, 6'd3, 6'd0, 6'd3},  rel:4'b0000, grant:4'b0001, err:1'b1};
        vecs[14] = '{req:4'b0111, ids:{6'd0, 6'd3, 6'd0, 6'd3},  rel:4'b0000, grant:4'b0001, err:1'b1};
        vecs[15] = '{req:4'b0110, ids:{6'd0, 6'd3, 6'd0, 6'd3},  rel:4'b0001, grant:4'b0010, err:1'b1};
        vecs[16] = '{req:4'b0100, ids:{6'd0, 6'd3, 6'd0, 6'd3},  rel:4'b0110, grant:4'b0100, err:1'b1};
        vecs[17] = '{req:4'b0000, ids:'0,                        rel:4'b0100, grant:4'b0000, err:1'b1};

        rst_n            = 1'b0;
        bus.req          = '0;
        bus.req_issue_id = '0;
        bus.release_lock = '0;
        for (int i = 0; i < N; i++) begin
            bus.in_op[i] = op_val(i);
            bus.in_a[i]  = a_val(i);
            bus.in_b[i]  = b_val(i);
        end

        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 4'b0000, 1'b0);
        rst_n = 1'b1;

        for (int k = 0; k < NV; k++) begin
            bus.req          = vecs[k].req;
            bus.req_issue_id = vecs[k].ids;
            bus.release_lock = vecs[k].rel;
            tick();
            chk_all($sformatf("vec%0d", k), vecs[k].grant, vecs[k].err);
        end
        bus.release_lock = '0;

        // Reset while locked: outputs must clear without waiting for a clock edge.
        bus.req          = 4'b1000;
        bus.req_issue_id = {6'd9, 6'd0, 6'd0, 6'd0};
        tick();
        chk_all("prelock", 4'b1000, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 4'b0000, 1'b0);
        tick();
        chk_all("rst_held_edge", 4'b0000, 1'b0);
        rst_n = 1'b1;
        #1;
        chk_all("rst_released", 4'b0000, 1'b0);
        tick();
        chk_all("first_edge_grant", 4'b1000, 1'b0);

        // Back-to-back hand-off: grant must go straight from owner 3 to owner 1.
        bus.req          = 4'b1010;
        bus.req_issue_id = {6'd9, 6'd0, 6'd4, 6'd0};
        bus.release_lock = 4'b1000;
        tick();
        chk_all("handoff", 4'b0010, 1'b0);
        bus.req          = 4'b0000;
        bus.release_lock = 4'b0010;
        tick();
        chk_all("final_release", 4'b0000, 1'b0);
        bus.release_lock = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
